regset_wb_ctrl: RTL and testbench
=================================

# regset_wb_ctrl

Writeback controller that owns the single write port of the processor register set. It accepts ALU results every cycle and buffers load results from memory through a valid/ready queue. It serialises both streams onto registered `write_enable`/`A_D`/`D` outputs that feed the register set directly. It also reports pending writes per read address so the decode stage can stall on in-flight loads.

## Interface
- `DEPTH`, 4, load-queue entries; power of two, at least 2.
- `XLEN`, 32, data width.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `RES`  in  1  reset; synchronous, active-high.
- `alu_valid`  in  1  ALU result present this cycle; always accepted, no ready.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `mem_valid`  in  1  load result offered.
- `mem_ready`  out  1  queue can accept; `mem_valid && mem_ready` is a transfer.
- `mem_rd`  in  5  load destination register.
- `mem_data`  in  XLEN  load result.
- `write_enable`  out  1  register-set write strobe (registered).
- `A_D`  out  5  register-set write address (registered).
- `D`  out  XLEN  register-set write data (registered).
- `A_Q0`, `A_Q1`  in  5  each  read addresses currently being decoded.
- `pending0`, `pending1`  out  1  each  a write to `A_Q0`/`A_Q1` is still outstanding.
- `count`  out  log2(DEPTH)+1  queue occupancy.

## Operation
- The load queue is a circular FIFO of `DEPTH` entries `{rd, data, kill}`, with head and tail pointers and an occupancy counter.
- Every ALU write is younger in program order than every queued load, including a load transferred in the same cycle.
- Enqueue:
  - On a transfer with `mem_rd != 0`, write `{mem_rd, mem_data, kill=0}` at the tail.
  - A transfer with `mem_rd == 0` completes the handshake but enqueues nothing.
- WAW kill: when `alu_valid && alu_rd != 0`, set `kill` on every valid entry whose `rd == alu_rd`. A same-cycle enqueued entry with a matching rd is written with `kill=1`.
- Issue priority, evaluated each cycle:
  - If `alu_valid && alu_rd != 0`, register the ALU write.
  - Else, if the queue is non-empty, pop the head. If it is not killed, register its write; if it is killed, pop it and register no write.
  - Otherwise `write_enable` = 0.
- Writes to `x0` are never issued. `A_D` and `D` hold their last values when `write_enable` = 0.
- `mem_ready` = `!RES && count < DEPTH`. This uses the registered count: there is no pass-through when full, even if a pop occurs in the same cycle.
- `pendingN` is combinational. It is 1 when `A_QN != 0` and either condition holds:
  - some valid, non-killed queue entry has `rd == A_QN`, or
  - `write_enable && A_D == A_QN`.
- Pointer wrap: pointers wrap modulo `DEPTH`. Full and empty are decided from `count`, not from pointer equality.

## Timing
- Reset (`RES` high at an edge):
  - `write_enable` = 0, `A_D` = 0, `D` = 0, `count` = 0, pointers = 0, all kill bits = 0.
  - `mem_ready` = 0 while `RES` is high.
  - Any queued loads are discarded.
  - A mid-stream reset aborts the output write registered in that cycle.
- ALU latency: `alu_valid` in cycle N gives `write_enable` = 1 in cycle N+1. The register set captures the write at the end of N+1.
- Load latency, with an empty queue and no ALU traffic: a transfer in cycle N is pushed at the end of N, popped in N+1, and `write_enable` = 1 in N+2.
- ALU starvation of loads is permitted: the queue drains only in cycles with no valid non-`x0` ALU write.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- At most one register-set write per cycle.

## Test plan
- Reset: hold `RES` for 2 cycles with `mem_valid`=1 → `write_enable`=0, `A_D`=0, `D`=0, `count`=0, `mem_ready`=0. After `RES` drops: `mem_ready`=1 and nothing is written.
- ALU path: `alu_valid`=1, `alu_rd`=5, `alu_data`=0xDEADBEEF for 1 cycle → next cycle `write_enable`=1, `A_D`=5, `D`=0xDEADBEEF; the cycle after, `write_enable`=0. With `alu_rd`=0, no write occurs.
- Load queue fill/drain, DEPTH=4:
  - Stimulus: hold `alu_valid`=1 on rd=1 while pushing loads to rd=2,3,4,6.
  - `mem_ready` falls with `count`=4; a fifth load stalls.
  - `pending0` is 1 for `A_Q0`=3.
  - Releasing ALU drains rd=2,3,4,6 in order on consecutive cycles, then the stalled fifth load is accepted.
- WAW kill: queue a load to rd=7 (data 0x11), then ALU write rd=7 (data 0x22) → only 0x22 is written to rd=7. The killed entry pops with no strobe. `pending` for rd 7 clears after the ALU write.
- Wrap-around: push and pop 10 loads (rd=1..10, data=rd×0x100) through DEPTH=4 with random `alu_valid` gaps → every write appears once, in order, and `count` never exceeds 4.
- Reset mid-drain: with 3 entries queued, assert `RES` for 1 cycle → `count`=0, and no queued rd is ever written afterward.

Source files
------------

// File: rtl/regset_wb_ctrl.sv
// regset_wb_ctrl: single-port register-set writeback arbiter with load queue and pending-write lookup
module regset_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     CLK,
  input  logic                     RES,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  output logic                     write_enable,
  output logic [4:0]               A_D,
  output logic [XLEN-1:0]          D,
  input  logic [4:0]               A_Q0,
  input  logic [4:0]               A_Q1,
  output logic                     pending0,
  output logic                     pending1,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]      q_rd   [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [DEPTH-1:0] q_kill, q_valid;
  logic [AW-1:0] head, tail;
  logic alu_go, push, pop, pop_live, hit0, hit1;
  assign alu_go    = alu_valid && alu_rd != 5'd0;
  assign mem_ready = !RES && count < (AW+1)'(DEPTH);
  assign push      = mem_valid && mem_ready && mem_rd != 5'd0;
  assign pop       = !alu_go && count != '0;
  assign pop_live  = pop && !q_kill[head];
  // An entry is live when its distance from head is below the occupancy
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      q_valid[i] = {1'b0, AW'(i) - head} < count;
  end
  // Queue bookkeeping: pointers, occupancy and WAW kill marks
  always_ff @(posedge CLK) begin
    if (RES) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      q_kill <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (alu_go && q_valid[i] && q_rd[i] == alu_rd) q_kill[i] <= 1'b1;
      if (push) begin
        q_kill[tail] <= alu_go && mem_rd == alu_rd;
        tail         <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // Load payload storage; liveness is tracked by count so no reset is needed
  always_ff @(posedge CLK) begin
    if (push) begin
      q_rd[tail]   <= mem_rd;
      q_data[tail] <= mem_data;
    end
  end
  // Registered write port: ALU first, otherwise the head load unless it was killed
  always_ff @(posedge CLK) begin
    if (RES) begin
      write_enable <= 1'b0;
      A_D          <= '0;
      D            <= '0;
    end else begin
      write_enable <= alu_go || pop_live;
      if (alu_go) begin
        A_D <= alu_rd;
        D   <= alu_data;
      end else if (pop_live) begin
        A_D <= q_rd[head];
        D   <= q_data[head];
      end
    end
  end
  // Pending lookup over live unkilled queue entries plus the write in flight
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i] && !q_kill[i] && q_rd[i] == A_Q0) hit0 = 1'b1;
      if (q_valid[i] && !q_kill[i] && q_rd[i] == A_Q1) hit1 = 1'b1;
    end
    pending0 = A_Q0 != 5'd0 && (hit0 || (write_enable && A_D == A_Q0));
    pending1 = A_Q1 != 5'd0 && (hit1 || (write_enable && A_D == A_Q1));
  end
endmodule

// File: tb/tb_regset_wb_ctrl.sv
// tb_regset_wb_ctrl: scoreboard bench for regset_wb_ctrl
module tb_regset_wb_ctrl;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  logic CLK = 1'b0;
  logic RES, alu_valid, mem_valid, mem_ready, write_enable, pending0, pending1;
  logic [4:0] alu_rd, mem_rd, A_D, A_Q0, A_Q1;
  logic [XLEN-1:0] alu_data, mem_data, D;
  logic [$clog2(DEPTH):0] count;

  always #5 CLK = ~CLK;

  regset_wb_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .CLK(CLK), .RES(RES),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .write_enable(write_enable), .A_D(A_D), .D(D),
    .A_Q0(A_Q0), .A_Q1(A_Q1), .pending0(pending0), .pending1(pending1),
    .count(count)
  );

  typedef struct {logic [4:0] rd; logic [31:0] data; bit kill;} ent_t;
  typedef struct {logic [4:0] rd; logic [31:0] data; int cyc;} wr_t;
  ent_t mq[$];
  wr_t  exp_q[$];
  wr_t  me;
  int   cyc = 0, checks = 0, errors = 0;
  bit   m_we = 0;
  logic [4:0] m_ad = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a register is pending if a live unkilled load targets it or it is being written now
  function automatic bit mpend(logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (m_we && m_ad == a) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == a && !mq[i].kill) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle of stimulus plus the reference-model update at the clock edge
  task automatic step(input bit r, input bit av, input logic [4:0] ar, input logic [31:0] ad,
                      input bit mv, input logic [4:0] mr, input logic [31:0] md,
                      input logic [4:0] q0, output bit acc);
    bit go, rdy, popped;
    ent_t h;
    RES = r; alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    A_Q0 = q0; A_Q1 = 5'($urandom_range(0, 31));
    #1;
    rdy = !r && mq.size() < DEPTH;
    chk("mem_ready", mem_ready, rdy);
    chk("count", count, mq.size());
    chk("pending0", pending0, mpend(A_Q0));
    chk("pending1", pending1, mpend(A_Q1));
    @(posedge CLK);
    cyc++;
    acc = mv && rdy;
    if (r) begin
      mq.delete();
      m_we = 0;
      m_ad = '0;
    end else begin
      go = av && ar != 5'd0;
      popped = 0;
      if (go) foreach (mq[i]) if (mq[i].rd == ar) mq[i].kill = 1;
      if (!go && mq.size() > 0) begin
        h = mq.pop_front();
        popped = 1;
      end
      if (acc && mr != 5'd0) mq.push_back('{mr, md, go && mr == ar});
      m_we = 0;
      if (go) begin
        exp_q.push_back('{ar, ad, cyc});
        m_we = 1;
        m_ad = ar;
      end else if (popped && !h.kill) begin
        exp_q.push_back('{h.rd, h.data, cyc});
        m_we = 1;
        m_ad = h.rd;
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n, input logic [4:0] q0);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, q0, a);
  endtask

  // Monitor: every strobe must match the oldest expected write, in its cycle
  always @(negedge CLK) begin
    if (write_enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write: got rd %0d data %0h at cycle %0d, expected no write", A_D, D, cyc);
      end else begin
        me = exp_q.pop_front();
        chk("wr_rd", A_D, me.rd);
        chk("wr_data", D, me.data);
        chk("wr_cycle", cyc, me.cyc);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      me = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_write: got write_enable 0 at cycle %0d, expected rd %0d data %0h", cyc, me.rd, me.data);
    end
  end

  initial begin
    bit acc;
    int k;
    logic [4:0] lds [5];
    lds = '{5'd2, 5'd3, 5'd4, 5'd6, 5'd9};
    RES = 1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 1; mem_rd = 5'd3; mem_data = 0; A_Q0 = 0; A_Q1 = 0;
    @(negedge CLK);
    // Reset held with a load offered
    step(1, 0, 0, 0, 1, 3, 'h33, 0, acc);
    step(1, 0, 0, 0, 1, 3, 'h33, 0, acc);
    chk("rst_we", write_enable, 0);
    chk("rst_ad", A_D, 0);
    chk("rst_d", D, 0);
    chk("rst_count", count, 0);
    idle(3, 3);
    // ALU path, then an x0 write that must not issue
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, acc);
    chk("alu_we", write_enable, 1);
    chk("alu_ad", A_D, 5);
    chk("alu_d", D, 32'hDEADBEEF);
    idle(1, 5);
    chk("alu_we_clear", write_enable, 0);
    step(0, 1, 0, 32'h1234, 0, 0, 0, 0, acc);
    idle(2, 0);
    // Fill under ALU starvation, stall a fifth load, then drain in order
    k = 0;
    for (int n = 0; n < 12 && k < 4; n++) begin
      step(0, 1, 1, $urandom, 1, lds[k], 32'(lds[k]) * 32'h10, 3, acc);
      if (acc) k++;
    end
    for (int n = 0; n < 3; n++) step(0, 1, 1, $urandom, 1, lds[4], 32'h90, 3, acc);
    chk("full_count", count, 4);
    chk("full_ready", mem_ready, 0);
    chk("full_pend3", pending0, 1);
    for (int n = 0; n < 12 && k < 5; n++) begin
      step(0, 0, 0, 0, 1, lds[4], 32'h90, 3, acc);
      if (acc) k++;
    end
    chk("fifth_accepted", k, 5);
    idle(8, 9);
    // WAW kill of a queued load by a younger ALU write
    step(0, 1, 1, 32'hA, 1, 7, 32'h11, 7, acc);
    step(0, 1, 7, 32'h22, 0, 0, 0, 7, acc);
    chk("waw_pend_inflight", pending0, 1);
    idle(1, 7);
    chk("waw_pend_clear", pending0, 0);
    chk("waw_drained", count, 0);
    idle(3, 7);
    // Wrap-around with random ALU gaps on unrelated registers
    k = 1;
    for (int n = 0; n < 200 && k <= 10; n++) begin
      step(0, 1'($urandom_range(0, 1)), 5'($urandom_range(11, 31)), $urandom,
           1, 5'(k), 32'(k) * 32'h100, 5'($urandom_range(0, 12)), acc);
      if (acc) k++;
    end
    chk("wrap_all_accepted", k, 11);
    idle(8, 4);
    // Reset while three loads are queued
    for (int n = 20; n < 23; n++) step(0, 1, 1, $urandom, 1, 5'(n), $urandom, 21, acc);
    chk("pre_rst_count", count, 3);
    step(1, 0, 0, 0, 1, 25, 0, 21, acc);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_we", write_enable, 0);
    idle(8, 21);
    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 60) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)), acc);
    idle(10, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
